// File: rtl/p405s_opnd_fwd_sel.sv
// Operand forward-stage selector: picks each decode port's operand address
// (RA/RB), tracks in-flight GPR write tags and reports youngest-stage hits.
//
// Ports:
//   CB, reset             clock, synchronous active-high reset
//   preDcdRA/preDcdRB     per-port candidate operand addresses (packed)
//   rdEn, bpMuxSel_NEG    per-port select controls (RA when both are 1)
//   dcdValid, dcdStall    decode slot valid / hold
//   flush                 kills the decode and exe slots
//   wrEn, wrAddr          decode instruction GPR write and destination
//   dcdPortAddr           selected operand address per port
//   fwdHit, fwdAny        per-port one-hot forward stage and its OR
//   stageValid            valid bit of each tracked stage
//
// Config macro: P405S_FWD_SELREG_EN registers dcdPortAddr/fwdHit/fwdAny.
module p405s_opnd_fwd_sel #(
    parameter int NPORTS = 2,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                     CB,
    input  logic                     reset,
    input  logic [NPORTS*ADDR_W-1:0] preDcdRA,
    input  logic [NPORTS*ADDR_W-1:0] preDcdRB,
    input  logic [NPORTS-1:0]        rdEn,
    input  logic [NPORTS-1:0]        bpMuxSel_NEG,
    input  logic                     dcdValid,
    input  logic                     dcdStall,
    input  logic                     flush,
    input  logic                     wrEn,
    input  logic [ADDR_W-1:0]        wrAddr,
    output logic [NPORTS*ADDR_W-1:0] dcdPortAddr,
    output logic [NPORTS*DEPTH-1:0]  fwdHit,
    output logic [NPORTS-1:0]        fwdAny,
    output logic [DEPTH-1:0]         stageValid
);

    // Tag pipeline: stage 0 = exe, rising index = older.
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  vld_d;
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [ADDR_W-1:0] tag_d [DEPTH];

    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        // Stage 0 takes a bubble on stall or flush; flush wins but
        // both just clear valid, so the address is simply held.
        if (!flush && !dcdStall) begin
            vld_d[0] = dcdValid & wrEn;
            tag_d[0] = wrAddr;
        end else begin
            vld_d[0] = 1'b0;
        end
        // Older stages always advance; flush also kills the
        // instruction moving out of exe into stage 1.
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = (i == 1 && flush) ? 1'b0 : vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign stageValid = vld_q;

    // Operand address select per port.
    logic [NPORTS*ADDR_W-1:0] sel_c;

    always_comb begin
        sel_c = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (rdEn[p] & bpMuxSel_NEG[p]) begin
                sel_c[p*ADDR_W +: ADDR_W] = preDcdRA[p*ADDR_W +: ADDR_W];
            end else begin
                sel_c[p*ADDR_W +: ADDR_W] = preDcdRB[p*ADDR_W +: ADDR_W];
            end
        end
    end

    // Tag compare against pre-edge stage contents; keep only the
    // youngest matching stage so duplicates yield a single hit.
    logic [NPORTS*DEPTH-1:0] hit_c;
    logic [NPORTS-1:0]       any_c;
    logic                    found;

    always_comb begin
        hit_c = '0;
        any_c = '0;
        found = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && vld_q[i] &&
                    tag_q[i] == sel_c[p*ADDR_W +: ADDR_W]) begin
                    hit_c[p*DEPTH + i] = 1'b1;
                    found              = 1'b1;
                end
            end
            any_c[p] = found;
        end
    end

`ifdef P405S_FWD_SELREG_EN
    logic [NPORTS*ADDR_W-1:0] addr_q;
    logic [NPORTS*ADDR_W-1:0] addr_d;
    logic [NPORTS*DEPTH-1:0]  hit_q;
    logic [NPORTS*DEPTH-1:0]  hit_d;
    logic [NPORTS-1:0]        any_q;
    logic [NPORTS-1:0]        any_d;

    always_comb begin
        addr_d = addr_q;
        hit_d  = hit_q;
        any_d  = any_q;
        if (!dcdStall) begin
            addr_d = sel_c;
            hit_d  = hit_c;
            any_d  = any_c;
        end
        // A flushed decode must not present a stale forward select.
        if (flush) begin
            hit_d = '0;
            any_d = '0;
        end
    end

    always_ff @(posedge CB) begin
        if (reset) begin
            addr_q <= '0;
            hit_q  <= '0;
            any_q  <= '0;
        end else begin
            addr_q <= addr_d;
            hit_q  <= hit_d;
            any_q  <= any_d;
        end
    end

    assign dcdPortAddr = addr_q;
    assign fwdHit      = hit_q;
    assign fwdAny      = any_q;
`else
    assign dcdPortAddr = sel_c;
    assign fwdHit      = hit_c;
    assign fwdAny      = any_c;
`endif

endmodule

// File: tb/tb_p405s_opnd_fwd_sel.sv
// Self-checking bench for p405s_opnd_fwd_sel with a tag-age reference model.
// Works in both combinational and registered (P405S_FWD_SELREG_EN) builds.
module tb_p405s_opnd_fwd_sel;

    localparam int NP = 2;
    localparam int AW = 10;
    localparam int D  = 4;

    logic             CB = 1'b0;
    logic             reset;
    logic [NP*AW-1:0] preDcdRA;
    logic [NP*AW-1:0] preDcdRB;
    logic [NP-1:0]    rdEn;
    logic [NP-1:0]    bpMuxSel_NEG;
    logic             dcdValid;
    logic             dcdStall;
    logic             flush;
    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [NP*AW-1:0] dcdPortAddr;
    logic [NP*D-1:0]  fwdHit;
    logic [NP-1:0]    fwdAny;
    logic [D-1:0]     stageValid;

    p405s_opnd_fwd_sel #(.NPORTS(NP), .ADDR_W(AW), .DEPTH(D)) dut (
        .CB          (CB),
        .reset       (reset),
        .preDcdRA    (preDcdRA),
        .preDcdRB    (preDcdRB),
        .rdEn        (rdEn),
        .bpMuxSel_NEG(bpMuxSel_NEG),
        .dcdValid    (dcdValid),
        .dcdStall    (dcdStall),
        .flush       (flush),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .dcdPortAddr (dcdPortAddr),
        .fwdHit      (fwdHit),
        .fwdAny      (fwdAny),
        .stageValid  (stageValid)
    );

    always #5 CB = ~CB;

    // Model: list of in-flight writes, each with its age (= stage index).
    typedef struct {
        logic [AW-1:0] addr;
        int            age;
    } ent_t;

    ent_t q[$];

    logic [NP*AW-1:0] r_addr;
    logic [NP*D-1:0]  r_hit;
    logic [NP-1:0]    r_any;

    int total = 0;
    int bad   = 0;

    function automatic logic [AW-1:0] sel_of(int p);
        if (rdEn[p] && bpMuxSel_NEG[p])
            return preDcdRA[p*AW +: AW];
        return preDcdRB[p*AW +: AW];
    endfunction

    function automatic int youngest(int p);
        int best = D;
        foreach (q[k])
            if (q[k].addr == sel_of(p) && q[k].age < best)
                best = q[k].age;
        return best;
    endfunction

    function automatic logic [NP*AW-1:0] now_addr();
        logic [NP*AW-1:0] v = '0;
        for (int p = 0; p < NP; p++) v[p*AW +: AW] = sel_of(p);
        return v;
    endfunction

    function automatic logic [NP*D-1:0] now_hit();
        logic [NP*D-1:0] v = '0;
        for (int p = 0; p < NP; p++)
            if (youngest(p) < D) v[p*D + youngest(p)] = 1'b1;
        return v;
    endfunction

    function automatic logic [NP-1:0] now_any();
        logic [NP-1:0] v = '0;
        for (int p = 0; p < NP; p++) v[p] = (youngest(p) < D);
        return v;
    endfunction

    function automatic logic [D-1:0] exp_sv();
        logic [D-1:0] v = '0;
        foreach (q[k]) v[q[k].age] = 1'b1;
        return v;
    endfunction

`ifdef P405S_FWD_SELREG_EN
    function automatic logic [NP*AW-1:0] exp_addr(); return r_addr; endfunction
    function automatic logic [NP*D-1:0]  exp_hit();  return r_hit;  endfunction
    function automatic logic [NP-1:0]    exp_any();  return r_any;  endfunction
`else
    function automatic logic [NP*AW-1:0] exp_addr(); return now_addr(); endfunction
    function automatic logic [NP*D-1:0]  exp_hit();  return now_hit();  endfunction
    function automatic logic [NP-1:0]    exp_any();  return now_any();  endfunction
`endif

    // Advance one clock and move the model with the inputs seen at the edge.
    task automatic tick();
        ent_t nq[$];
        @(posedge CB);
        if (reset) begin
            q.delete();
            r_addr = '0;
            r_hit  = '0;
            r_any  = '0;
        end else begin
            if (!dcdStall) r_addr = now_addr();
            if (flush) begin
                r_hit = '0;
                r_any = '0;
            end else if (!dcdStall) begin
                r_hit = now_hit();
                r_any = now_any();
            end
            foreach (q[k]) begin
                if (!(flush && q[k].age == 0) && q[k].age + 1 < D)
                    nq.push_back('{addr: q[k].addr, age: q[k].age + 1});
            end
            if (!dcdStall && !flush && dcdValid && wrEn)
                nq.push_back('{addr: wrAddr, age: 0});
            q = nq;
        end
        #1;
    endtask

    task automatic set_idle();
        reset        = 1'b0;
        preDcdRA     = '0;
        preDcdRB     = '0;
        rdEn         = '0;
        bpMuxSel_NEG = '0;
        dcdValid     = 1'b0;
        dcdStall     = 1'b0;
        flush        = 1'b0;
        wrEn         = 1'b0;
        wrAddr       = '0;
    endtask

    task automatic drain();
        set_idle();
        for (int i = 0; i < D + 1; i++) tick();
    endtask

    task automatic test_reset();
        set_idle();
        reset    = 1'b1;
        dcdValid = 1'b1;
        wrEn     = 1'b1;
        wrAddr   = 10'h005;
        flush    = 1'($urandom_range(0, 1));
        tick();
        tick();
        set_idle();
        preDcdRB = {10'h012, 10'h034};
        #1;
        total++;
        if (stageValid !== exp_sv()) begin
            bad++;
            $display("FAIL reset_sv got=%h exp=%h", stageValid, exp_sv());
        end
        total++;
        if (fwdHit !== '0) begin
            bad++;
            $display("FAIL reset_hit got=%h exp=0", fwdHit);
        end
        total++;
        if (fwdAny !== '0) begin
            bad++;
            $display("FAIL reset_any got=%h exp=0", fwdAny);
        end
        total++;
        if (dcdPortAddr !== exp_addr()) begin
            bad++;
            $display("FAIL reset_addr got=%h exp=%h", dcdPortAddr, exp_addr());
        end
    endtask

    task automatic test_select();
        set_idle();
        rdEn         = 2'b11;
        bpMuxSel_NEG = 2'b01;
        preDcdRA     = {10'h0F0, 10'h005};
        preDcdRB     = {10'h0F1, 10'h007};
        tick();
        total++;
        if (dcdPortAddr[AW-1:0] !== 10'h005 ||
            dcdPortAddr !== exp_addr()) begin
            bad++;
            $display("FAIL sel_ra got=%h exp=%h", dcdPortAddr, exp_addr());
        end
        bpMuxSel_NEG = 2'b00;
        tick();
        total++;
        if (dcdPortAddr[AW-1:0] !== 10'h007 ||
            dcdPortAddr !== exp_addr()) begin
            bad++;
            $display("FAIL sel_rb got=%h exp=%h", dcdPortAddr, exp_addr());
        end
        for (int i = 0; i < 6; i++) begin
            rdEn         = 2'($urandom);
            bpMuxSel_NEG = 2'($urandom);
            preDcdRA     = 20'($urandom);
            preDcdRB     = 20'($urandom);
            tick();
            total++;
            if (dcdPortAddr !== exp_addr()) begin
                bad++;
                $display("FAIL sel_rand got=%h exp=%h",
                         dcdPortAddr, exp_addr());
            end
        end
    endtask

    task automatic test_chain();
        drain();
        rdEn         = 2'b01;
        bpMuxSel_NEG = 2'b01;
        preDcdRA     = {10'h000, 10'h005};
        preDcdRB     = {10'h3FF, 10'h3FF};
        dcdValid     = 1'b1;
        wrEn         = 1'b1;
        wrAddr       = 10'h005;
        tick();
        wrEn = 1'b0;
        for (int i = 0; i < D + 2; i++) begin
            #1;
            total++;
            if (fwdHit !== exp_hit() || fwdAny !== exp_any()) begin
                bad++;
                $display("FAIL chain_%0d got=%h/%h exp=%h/%h", i,
                         fwdHit, fwdAny, exp_hit(), exp_any());
            end
            tick();
        end
    endtask

    task automatic test_youngest();
        drain();
        rdEn         = 2'b11;
        bpMuxSel_NEG = 2'b11;
        preDcdRA     = {10'h003, 10'h003};
        dcdValid     = 1'b1;
        wrEn         = 1'b1;
        wrAddr       = 10'h003;
        tick();
        tick();
        wrEn = 1'b0;
        tick();
        total++;
        if (fwdHit !== exp_hit() || fwdAny !== exp_any()) begin
            bad++;
            $display("FAIL youngest got=%h/%h exp=%h/%h",
                     fwdHit, fwdAny, exp_hit(), exp_any());
        end
        tick();
        total++;
        if (fwdHit !== exp_hit() || fwdAny !== exp_any()) begin
            bad++;
            $display("FAIL youngest2 got=%h/%h exp=%h/%h",
                     fwdHit, fwdAny, exp_hit(), exp_any());
        end
    endtask

    task automatic test_stall();
        drain();
        rdEn         = 2'b01;
        bpMuxSel_NEG = 2'b01;
        preDcdRA     = {10'h000, 10'h009};
        dcdValid     = 1'b1;
        wrEn         = 1'b1;
        wrAddr       = 10'h009;
        tick();
        tick();
        total++;
        if (stageValid !== exp_sv()) begin
            bad++;
            $display("FAIL stall_pre got=%b exp=%b", stageValid, exp_sv());
        end
        dcdStall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (stageValid !== exp_sv() || fwdHit !== exp_hit()) begin
                bad++;
                $display("FAIL stall_%0d got=%b/%h exp=%b/%h", i,
                         stageValid, fwdHit, exp_sv(), exp_hit());
            end
        end
        dcdStall = 1'b0;
        wrEn     = 1'b0;
    endtask

    task automatic test_flush();
        drain();
        rdEn         = 2'b11;
        bpMuxSel_NEG = 2'b11;
        preDcdRA     = {10'h00B, 10'h00A};
        dcdValid     = 1'b1;
        wrEn         = 1'b1;
        wrAddr       = 10'h00B;
        tick();
        wrAddr   = 10'h00A;
        flush    = 1'b1;
        dcdStall = 1'b1;
        tick();
        flush    = 1'b0;
        dcdStall = 1'b0;
        wrEn     = 1'b0;
        #1;
        total++;
        if (stageValid !== exp_sv()) begin
            bad++;
            $display("FAIL flush_sv got=%b exp=%b", stageValid, exp_sv());
        end
        total++;
        if (fwdHit !== exp_hit() || fwdAny !== exp_any()) begin
            bad++;
            $display("FAIL flush_hit got=%h/%h exp=%h/%h",
                     fwdHit, fwdAny, exp_hit(), exp_any());
        end
    endtask

    task automatic test_random();
        set_idle();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 49) == 0);
            dcdValid = ($urandom_range(0, 3) != 0);
            wrEn     = ($urandom_range(0, 2) != 0);
            dcdStall = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            wrAddr   = AW'($urandom_range(0, 7));
            rdEn         = 2'($urandom);
            bpMuxSel_NEG = 2'($urandom);
            for (int p = 0; p < NP; p++) begin
                preDcdRA[p*AW +: AW] = AW'($urandom_range(0, 7));
                preDcdRB[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            #1;
            total++;
            if (fwdHit !== exp_hit() || fwdAny !== exp_any() ||
                dcdPortAddr !== exp_addr() || stageValid !== exp_sv()) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", c,
                         fwdHit, fwdAny, dcdPortAddr, stageValid,
                         exp_hit(), exp_any(), exp_addr(), exp_sv());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        rdEn         = 2'b11;
        bpMuxSel_NEG = 2'b11;
        preDcdRA     = {10'h004, 10'h004};
        dcdValid     = 1'b1;
        wrEn         = 1'b1;
        wrAddr       = 10'h004;
        tick();
        tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        wrEn  = 1'b0;
        #1;
        total++;
        if (stageValid !== 4'b0000 || stageValid !== exp_sv()) begin
            bad++;
            $display("FAIL rstmid_sv got=%b exp=0000", stageValid);
        end
        total++;
        if (fwdHit !== '0 || fwdAny !== '0) begin
            bad++;
            $display("FAIL rstmid_hit got=%h/%h exp=0/0", fwdHit, fwdAny);
        end
        total++;
        if (dcdPortAddr !== exp_addr()) begin
            bad++;
            $display("FAIL rstmid_addr got=%h exp=%h",
                     dcdPortAddr, exp_addr());
        end
    endtask

    initial begin
        r_addr = '0;
        r_hit  = '0;
        r_any  = '0;
        set_idle();
        test_reset();
        test_select();
        test_chain();
        test_youngest();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
